fps_meter: RTL and testbench

FPS_METER -- requirements
Module: fps_meter

---
 rtl/fps_meter_if.sv | 27 ++
 rtl/fps_meter.sv | 150 +++++++++++++++
 tb/tb_fps_meter.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/fps_meter_if.sv
// Frame-rate meter signal bundle: VSYNC strobe in, measurement results out.
// The master modport is the meter side; the slave modport is the consumer/stimulus side.
interface fps_meter_if #(
    parameter int unsigned COUNT_W = 8
);
    logic               VSYNC;
    logic [COUNT_W-1:0] FPS;
    logic               FPS_VALID;
    logic               OVERFLOW;
    logic               LED4;

    modport master (
        input  VSYNC,
        output FPS,
        output FPS_VALID,
        output OVERFLOW,
        output LED4
    );

    modport slave (
        output VSYNC,
        input  FPS,
        input  FPS_VALID,
        input  OVERFLOW,
        input  LED4
    );
endinterface

// File: rtl/fps_meter.sv
// Counts VSYNC rising edges per window of CLOCKS_PER_SEC cycles and publishes the count.
// Optional macro FPS_METER_LED_EN: when defined, LED4 toggles on every completed window.
module fps_meter #(
    parameter int unsigned CLOCKS_PER_SEC = 3287000,
    parameter int unsigned COUNT_W        = 8
) (
    input  logic         CLK_3P3_MHZ,
    input  logic         RST_N,
    fps_meter_if.master  bus
);

    localparam int unsigned CNT_W = (CLOCKS_PER_SEC > 1) ? $clog2(CLOCKS_PER_SEC) : 1;
    localparam logic [CNT_W-1:0]   WIN_LAST  = CNT_W'(CLOCKS_PER_SEC - 1);
    localparam logic [COUNT_W-1:0] FRAME_MAX = '1;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic               vs_meta, vs_sync, vs_prev;
    logic [1:0]         fill_q;
    logic               armed_q;
    logic               vs_rise;
    logic [CNT_W-1:0]   win_q, win_d;
    logic [COUNT_W-1:0] frame_q, frame_d, frame_cnt;
    logic               ovf_q, ovf_d, ovf_cnt;
    logic               close_win;
    logic [COUNT_W-1:0] fps_q;
    logic               fps_valid_q;
    logic               overflow_q;

    // A level already high at reset release must not look like an edge: the detector is
    // armed only once the settled synchroniser output has been observed low.
    always_ff @(posedge CLK_3P3_MHZ or negedge RST_N) begin
        if (!RST_N) begin
            vs_meta <= 1'b0;
            vs_sync <= 1'b0;
            vs_prev <= 1'b0;
            fill_q  <= '0;
            armed_q <= 1'b0;
        end else begin
            vs_meta <= bus.VSYNC;
            vs_sync <= vs_meta;
            vs_prev <= vs_sync;
            fill_q  <= {fill_q[0], 1'b1};
            if (fill_q[1] && !vs_sync)
                armed_q <= 1'b1;
        end
    end

    assign vs_rise = vs_sync & ~vs_prev & armed_q;

    always_comb begin
        frame_cnt = frame_q;
        ovf_cnt   = ovf_q;
        if (vs_rise) begin
            if (frame_q == FRAME_MAX)
                ovf_cnt = 1'b1;
            else
                frame_cnt = frame_q + COUNT_W'(1);
        end
    end

    always_ff @(posedge CLK_3P3_MHZ or negedge RST_N) begin
        if (!RST_N)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        win_d     = win_q;
        frame_d   = frame_q;
        ovf_d     = ovf_q;
        close_win = 1'b0;
        case (state_q)
            IDLE: begin
                win_d   = '0;
                frame_d = '0;
                ovf_d   = 1'b0;
                if (vs_rise) begin
                    state_d = MEASURE;
                    frame_d = COUNT_W'(1);
                end
            end
            MEASURE: begin
                frame_d = frame_cnt;
                ovf_d   = ovf_cnt;
                if (win_q == WIN_LAST) begin
                    // Closing cycle: an edge here lands in frame_cnt, which is published below.
                    close_win = 1'b1;
                    win_d     = '0;
                    frame_d   = '0;
                    ovf_d     = 1'b0;
                end else begin
                    win_d = win_q + CNT_W'(1);
                end
            end
        endcase
    end

    always_ff @(posedge CLK_3P3_MHZ or negedge RST_N) begin
        if (!RST_N) begin
            win_q   <= '0;
            frame_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            win_q   <= win_d;
            frame_q <= frame_d;
            ovf_q   <= ovf_d;
        end
    end

    always_ff @(posedge CLK_3P3_MHZ or negedge RST_N) begin
        if (!RST_N) begin
            fps_q       <= '0;
            fps_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            fps_valid_q <= close_win;
            if (close_win) begin
                fps_q      <= frame_cnt;
                overflow_q <= ovf_cnt;
            end
        end
    end

`ifdef FPS_METER_LED_EN
    logic led_q;

    always_ff @(posedge CLK_3P3_MHZ or negedge RST_N) begin
        if (!RST_N)
            led_q <= 1'b0;
        else if (close_win)
            led_q <= ~led_q;
    end

    assign bus.LED4 = led_q;
`else
    assign bus.LED4 = 1'b0;
`endif

    assign bus.FPS       = fps_q;
    assign bus.FPS_VALID = fps_valid_q;
    assign bus.OVERFLOW  = overflow_q;

endmodule

// File: tb/tb_fps_meter.sv
// Directed bench for fps_meter with CLOCKS_PER_SEC=100, COUNT_W=4.
// Every FPS_VALID pulse is logged on the falling edge and checked against hand-derived values.
module tb_fps_meter;

    localparam int unsigned CPS = 100;
    localparam int unsigned CW  = 4;
`ifdef FPS_METER_LED_EN
    localparam int LED_ON = 1;
`else
    localparam int LED_ON = 0;
`endif

    typedef struct {
        int cyc;
        int fps;
        int ovf;
        int led;
    } ev_t;

    logic CLK_3P3_MHZ = 1'b0;
    logic RST_N;
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    int   t0;
    ev_t  evq[$];

    fps_meter_if #(.COUNT_W(CW)) bus ();

    fps_meter #(
        .CLOCKS_PER_SEC(CPS),
        .COUNT_W       (CW)
    ) dut (
        .CLK_3P3_MHZ(CLK_3P3_MHZ),
        .RST_N      (RST_N),
        .bus        (bus)
    );

    always #5 CLK_3P3_MHZ = ~CLK_3P3_MHZ;

    always @(posedge CLK_3P3_MHZ) cyc <= cyc + 1;

    always @(negedge CLK_3P3_MHZ) begin
        if (bus.FPS_VALID === 1'b1)
            evq.push_back('{cyc, int'(bus.FPS), int'(bus.OVERFLOW), int'(bus.LED4)});
    end

    task automatic tick();
        @(posedge CLK_3P3_MHZ);
        #1;
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_ev(input string tag, input int k, input int fps, input int ovf, input int led);
        if (k < evq.size()) begin
            check({tag, "_fps"}, evq[k].fps, fps);
            check({tag, "_ovf"}, evq[k].ovf, ovf);
            check({tag, "_led"}, evq[k].led, led);
        end else begin
            checks++;
            errors++;
            $error("FAIL %s: event %0d missing, observed %0d events", tag, k, evq.size());
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_fps"},   int'(bus.FPS),       0);
        check({tag, "_valid"}, int'(bus.FPS_VALID), 0);
        check({tag, "_ovf"},   int'(bus.OVERFLOW),  0);
        check({tag, "_led"},   int'(bus.LED4),      0);
    endtask

    // Reset with VSYNC at the given level, release, then idle five cycles at that level.
    task automatic do_reset(input logic vs_level);
        bus.VSYNC = vs_level;
        RST_N = 1'b0;
        repeat (3) tick();
        RST_N = 1'b1;
        repeat (5) tick();
        evq.delete();
    endtask

    // Iteration i drives VSYNC for one cycle; 2-cycle pulses at i=0 and at first+k*period.
    task automatic drive(input int i_from, input int i_to, input int first, input int period);
        for (int i = i_from; i < i_to; i++) begin
            bus.VSYNC = (i < 2) || (i >= first && ((i - first) % period) < 2);
            tick();
        end
    endtask

    initial begin
        RST_N     = 1'b1;
        bus.VSYNC = 1'b0;
        #2;
        RST_N = 1'b0;
        #1;
        check_outputs_zero("reset_async");
        repeat (2) tick();
        RST_N = 1'b1;
        repeat (5) tick();
        check_outputs_zero("reset_idle");

        // Steady rate: start edge, then edges at offsets 30,50,...; windows hold 5 edges each.
        do_reset(1'b0);
        t0 = cyc;
        drive(0, 350, 30, 20);
        check("steady_count", evq.size(), 3);
        check_ev("steady_w1", 0, 5, 0, LED_ON);
        check_ev("steady_w2", 1, 5, 0, 0);
        check_ev("steady_w3", 2, 5, 0, LED_ON);
        if (evq.size() >= 3) begin
            check("steady_first_cyc", evq[0].cyc - t0, 103);
            check("steady_period_1", evq[1].cyc - evq[0].cyc, 100);
            check("steady_period_2", evq[2].cyc - evq[1].cyc, 100);
        end
        check("steady_hold_fps", int'(bus.FPS), 5);
        check("steady_valid_low", int'(bus.FPS_VALID), 0);

        // Saturation: an edge every 4 cycles overflows a 4-bit count, then the rate drops.
        do_reset(1'b0);
        drive(0, 200, 4, 4);
        drive(200, 400, 210, 20);
        check("sat_count", evq.size(), 3);
        check_ev("sat_w1", 0, 15, 1, LED_ON);
        check_ev("sat_w2", 1, 15, 1, 0);
        check_ev("sat_w3", 2, 5, 0, LED_ON);
        check("sat_hold_ovf", int'(bus.OVERFLOW), 0);

        // Boundary: the edge at offset 100 lands on the terminal cycle of window 1.
        do_reset(1'b0);
        drive(0, 250, 20, 20);
        check("bound_count", evq.size(), 2);
        check_ev("bound_w1", 0, 6, 0, LED_ON);
        check_ev("bound_w2", 1, 5, 0, 0);

        // Reset mid-window with VSYNC held high across release.
        do_reset(1'b0);
        drive(0, 150, 30, 20);
        check("midrst_pre_count", evq.size(), 1);
        check_ev("midrst_pre", 0, 5, 0, LED_ON);
        bus.VSYNC = 1'b1;
        #2;
        RST_N = 1'b0;
        #1;
        check_outputs_zero("midrst_async");
        repeat (3) tick();
        RST_N = 1'b1;
        evq.delete();
        repeat (200) tick();
        check("midrst_held_high_count", evq.size(), 0);
        check("midrst_held_fps", int'(bus.FPS), 0);
        bus.VSYNC = 1'b0;
        repeat (5) tick();
        drive(0, 110, 1000, 20);
        check("midrst_post_count", evq.size(), 1);
        check_ev("midrst_post", 0, 1, 0, LED_ON);

        // No VSYNC activity: no window ever starts.
        do_reset(1'b0);
        repeat (1000) tick();
        check("idle_count", evq.size(), 0);
        check("idle_valid", int'(bus.FPS_VALID), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
